// File: rtl/mc_sample_buffer_pkg.sv
// Shared sizing for the multi-channel sample buffer.
// Holds the default geometry and the width helpers used by the interface, the top and the
// per-channel history block, so every file derives identical widths from the same parameters.
package mc_sample_buffer_pkg;

  localparam int unsigned DEF_NUM_CH = 7;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 10;

  // A single channel still needs a 1-bit index port.
  function automatic int unsigned calc_ch_w(int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned calc_tap_w(int unsigned depth);
    return $clog2(depth);
  endfunction

  // Fill count runs 0..DEPTH inclusive.
  function automatic int unsigned calc_cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH full-scale samples always fit, so the moving sum never wraps.
  function automatic int unsigned calc_sum_w(int unsigned data_w, int unsigned depth);
    return data_w + $clog2(depth + 1);
  endfunction

  localparam int unsigned DEF_CH_W  = calc_ch_w(DEF_NUM_CH);
  localparam int unsigned DEF_TAP_W = calc_tap_w(DEF_DEPTH);
  localparam int unsigned DEF_SUM_W = calc_sum_w(DEF_DATA_W, DEF_DEPTH);

endpackage

// File: rtl/mc_sample_buffer_if.sv
// Sample-write / tap-read bus of the multi-channel sample buffer.
// master: drives clr, the sample offer (in_valid/in_ch/in_data) and the read request
//         (rd_req/rd_ch/rd_tap); observes in_ready, in_err, read results and full flags.
// slave:  the buffer side of the same signals.
interface mc_sample_buffer_if
  import mc_sample_buffer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
);
  localparam int unsigned CH_W  = calc_ch_w(NUM_CH);
  localparam int unsigned TAP_W = calc_tap_w(DEPTH);
  localparam int unsigned SUM_W = calc_sum_w(DATA_W, DEPTH);

  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              in_err;
  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic [TAP_W-1:0]  rd_tap;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;
  logic [SUM_W-1:0]  rd_sum;
  logic [NUM_CH-1:0] full;

  modport master (
    output clr, in_valid, in_ch, in_data, rd_req, rd_ch, rd_tap,
    input  in_ready, in_err, rd_valid, rd_data, rd_hit, rd_sum, full
  );

  modport slave (
    input  clr, in_valid, in_ch, in_data, rd_req, rd_ch, rd_tap,
    output in_ready, in_err, rd_valid, rd_data, rd_hit, rd_sum, full
  );

endinterface

// File: rtl/mc_sample_buffer_sample_history_ch.sv
// One channel of sample history: a DEPTH-deep shift line, a saturating fill count and an
// exact moving sum over the retained samples.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i synchronous clear;
//        wr_en_i/wr_data_i shift in a new newest sample; taps_o (tap 0 = newest),
//        count_o, sum_o, full_o expose registered state.
module sample_history_ch
  import mc_sample_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH),
  localparam int unsigned SUM_W = calc_sum_w(DATA_W, DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [DEPTH-1:0][DATA_W-1:0]  taps_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [SUM_W-1:0]              sum_o,
  output logic                          full_o
);

  logic [DEPTH-1:0][DATA_W-1:0] taps_d, taps_q;
  logic [CNT_W-1:0]             count_d, count_q;
  logic [SUM_W-1:0]             sum_d, sum_q;
  logic                         full;

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    taps_d  = taps_q;
    count_d = count_q;
    sum_d   = sum_q;
    if (clr_i) begin
      taps_d  = '0;
      count_d = '0;
      sum_d   = '0;
    end else if (wr_en_i) begin
      taps_d = {taps_q[DEPTH-2:0], wr_data_i};
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
      // The oldest tap only leaves the window once the line is full.
      sum_d = sum_q + SUM_W'(wr_data_i) - (full ? SUM_W'(taps_q[DEPTH-1]) : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taps_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      taps_q  <= taps_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  assign taps_o  = taps_q;
  assign count_o = count_q;
  assign sum_o   = sum_q;
  assign full_o  = full;

endmodule

// File: rtl/mc_sample_buffer.sv
// Multi-channel sample buffer: NUM_CH independent histories of the last DEPTH samples with a
// moving sum each, written through a valid/ready port and read one tap per cycle.
// Ports: clk, rst_n (async active-low); bus (slave) carries clr, the sample write handshake,
//        in_err, the registered read request/response and per-channel full flags.
module mc_sample_buffer
  import mc_sample_buffer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_sample_buffer_if.slave   bus
);

  localparam int unsigned CH_W  = calc_ch_w(NUM_CH);
  localparam int unsigned TAP_W = calc_tap_w(DEPTH);
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH);
  localparam int unsigned SUM_W = calc_sum_w(DATA_W, DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] taps   [NUM_CH];
  logic [CNT_W-1:0]             counts [NUM_CH];
  logic [SUM_W-1:0]             sums   [NUM_CH];
  logic [NUM_CH-1:0]            full_vec;
  logic [NUM_CH-1:0]            wr_en;

  logic accept, in_ch_ok;
  logic rd_ch_ok, rd_tap_ok;
  logic [CH_W-1:0]   rd_sel_ch;
  logic [TAP_W-1:0]  rd_sel_tap;

  logic              in_err_d, in_err_q;
  logic              rd_valid_d, rd_valid_q;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_hit_d, rd_hit_q;
  logic [SUM_W-1:0]  rd_sum_d, rd_sum_q;

  assign bus.in_ready = ~bus.clr;
  assign accept       = bus.in_valid & ~bus.clr;
  assign in_ch_ok     = 32'(bus.in_ch) < NUM_CH;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_en[g] = accept && in_ch_ok && (bus.in_ch == CH_W'(g));

    sample_history_ch #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_hist (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clr_i     (bus.clr),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (bus.in_data),
      .taps_o    (taps[g]),
      .count_o   (counts[g]),
      .sum_o     (sums[g]),
      .full_o    (full_vec[g])
    );
  end

  assign bus.full = full_vec;

  // Out-of-range indices are steered to 0 so the array is never addressed past its end;
  // the ok flags force the miss result regardless of what that entry holds.
  assign rd_ch_ok   = 32'(bus.rd_ch) < NUM_CH;
  assign rd_tap_ok  = 32'(bus.rd_tap) < DEPTH;
  assign rd_sel_ch  = rd_ch_ok ? bus.rd_ch : '0;
  assign rd_sel_tap = rd_tap_ok ? bus.rd_tap : '0;

  // Reads sample the registered history, so a same-cycle write or clr is not yet visible.
  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = rd_data_q;
    rd_hit_d   = rd_hit_q;
    rd_sum_d   = rd_sum_q;
    in_err_d   = accept && !in_ch_ok;
    if (bus.rd_req) begin
      rd_hit_d  = rd_ch_ok && rd_tap_ok && (32'(bus.rd_tap) < 32'(counts[rd_sel_ch]));
      rd_data_d = rd_hit_d ? taps[rd_sel_ch][rd_sel_tap] : '0;
      rd_sum_d  = (rd_ch_ok && rd_tap_ok) ? sums[rd_sel_ch] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_hit_q   <= 1'b0;
      rd_sum_q   <= '0;
    end else begin
      in_err_q   <= in_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_hit_q   <= rd_hit_d;
      rd_sum_q   <= rd_sum_d;
    end
  end

  assign bus.in_err   = in_err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.rd_sum   = rd_sum_q;

endmodule

// File: tb/tb_mc_sample_buffer.sv
// Bench for mc_sample_buffer: directed vectors with literal expectations, plus a queue-based
// reference model checked against the DUT on every falling clock edge.
module tb_mc_sample_buffer;
  import mc_sample_buffer_pkg::*;

  localparam int unsigned NUM_CH = DEF_NUM_CH;
  localparam int unsigned DATA_W = DEF_DATA_W;
  localparam int unsigned DEPTH  = DEF_DEPTH;
  localparam int unsigned CH_W   = calc_ch_w(NUM_CH);
  localparam int unsigned TAP_W  = calc_tap_w(DEPTH);

  logic clk;
  logic rst_n;

  mc_sample_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mc_sample_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a queue of retained samples, newest at the front.
  int unsigned mq [NUM_CH][$];
  logic        exp_valid, exp_hit, exp_err;
  int unsigned exp_data, exp_sum;

  initial begin
    exp_valid = 1'b0;
    exp_hit   = 1'b0;
    exp_err   = 1'b0;
    exp_data  = 0;
    exp_sum   = 0;
  end

  function automatic logic [NUM_CH-1:0] model_full();
    logic [NUM_CH-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int c;
    int unsigned s;
    int unsigned tap;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      exp_valid <= 1'b0;
      exp_hit   <= 1'b0;
      exp_err   <= 1'b0;
      exp_data  <= 0;
      exp_sum   <= 0;
    end else begin
      exp_valid <= bus.rd_req;
      if (bus.rd_req) begin
        if (int'(bus.rd_ch) < NUM_CH && int'(bus.rd_tap) < DEPTH) begin
          c   = int'(bus.rd_ch);
          tap = bus.rd_tap;
          s   = 0;
          for (int k = 0; k < mq[c].size(); k++) s += mq[c][k];
          exp_hit  <= (tap < mq[c].size());
          exp_data <= (tap < mq[c].size()) ? mq[c][tap] : 0;
          exp_sum  <= s;
        end else begin
          exp_hit  <= 1'b0;
          exp_data <= 0;
          exp_sum  <= 0;
        end
      end
      exp_err <= bus.in_valid && !bus.clr && (int'(bus.in_ch) >= NUM_CH);
      if (bus.clr) begin
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      end else if (bus.in_valid && int'(bus.in_ch) < NUM_CH) begin
        c = int'(bus.in_ch);
        mq[c].push_front(bus.in_data);
        if (mq[c].size() > DEPTH) void'(mq[c].pop_back());
      end
    end
  end

  // Read outputs are compared on every cycle, which also checks they hold while idle.
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, !bus.clr);
    chk("full", bus.full, model_full());
    chk("in_err", bus.in_err, exp_err);
    chk("rd_valid", bus.rd_valid, exp_valid);
    chk("rd_data", bus.rd_data, exp_data);
    chk("rd_hit", bus.rd_hit, exp_hit);
    chk("rd_sum", bus.rd_sum, exp_sum);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(ch);
    bus.in_data  = DATA_W'(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input int ch, input int tap);
    bus.rd_req = 1'b1;
    bus.rd_ch  = CH_W'(ch);
    bus.rd_tap = TAP_W'(tap);
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic rd_lit(input string name, input int d, input int h, input int s);
    chk({name, "_valid"}, bus.rd_valid, 1);
    chk({name, "_data"}, bus.rd_data, d);
    chk({name, "_hit"}, bus.rd_hit, h);
    chk({name, "_sum"}, bus.rd_sum, s);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.in_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_ch    = '0;
    bus.rd_tap   = '0;
    tick();
    tick();
    chk("rst_full", bus.full, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_sum", bus.rd_sum, 0);
    rst_n = 1'b1;

    // Invalid channel: error pulse, nothing stored.
    wr(7, 99);
    chk("err_pulse", bus.in_err, 1);
    chk("err_full", bus.full, 0);
    tick();
    chk("err_drop", bus.in_err, 0);
    rd(0, 0);
    rd_lit("err_sum0", 0, 0, 0);

    // Channel 2 filled past capacity.
    for (int v = 1; v <= 12; v++) begin
      wr(2, v);
      if (v == 9)  chk("full2_at9", bus.full, 0);
      if (v == 10) chk("full2_at10", bus.full, 7'b0000100);
    end
    bus.rd_req = 1'b1;
    bus.rd_ch  = 3'd2;
    bus.rd_tap = '0;
    tick();
    rd_lit("ch2_tap0", 12, 1, 75);
    bus.rd_tap = TAP_W'(9);
    tick();
    rd_lit("ch2_tap9", 3, 1, 75);
    bus.rd_req = 1'b0;
    tick();
    chk("hold_valid", bus.rd_valid, 0);
    chk("hold_data", bus.rd_data, 3);

    // Partially filled channel 0.
    wr(0, 5);
    wr(0, 6);
    rd(0, 1);
    rd_lit("ch0_tap1", 5, 1, 11);
    rd(0, 2);
    rd_lit("ch0_tap2", 0, 0, 11);
    rd(0, 12);
    rd_lit("ch0_tap12", 0, 0, 0);

    // Channel 1 at full scale: the sum needs its extra bits.
    for (int v = 0; v < 10; v++) wr(1, 255);
    rd(1, 0);
    rd_lit("ch1_sum_full", 255, 1, 2550);
    wr(1, 0);
    rd(1, 0);
    rd_lit("ch1_sum_after0", 0, 1, 2295);

    // Clear with a concurrent sample and read on channel 3.
    for (int v = 10; v < 20; v++) wr(3, v);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_ch    = 3'd3;
    bus.in_data  = 8'd200;
    bus.rd_req   = 1'b1;
    bus.rd_ch    = 3'd3;
    bus.rd_tap   = '0;
    #1;
    chk("clr_in_ready", bus.in_ready, 0);
    tick();
    rd_lit("clr_preread", 19, 1, 145);
    chk("clr_full", bus.full, 0);
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rd_lit("clr_postread", 0, 0, 0);
    bus.rd_req = 1'b0;
    tick();

    // Reset lands between a read request and its response.
    wr(4, 77);
    bus.rd_req = 1'b1;
    bus.rd_ch  = 3'd4;
    bus.rd_tap = '0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    chk("rstmid_valid", bus.rd_valid, 0);
    chk("rstmid_sum", bus.rd_sum, 0);
    chk("rstmid_hit", bus.rd_hit, 0);
    chk("rstmid_data", bus.rd_data, 0);
    chk("rstmid_full", bus.full, 0);
    rst_n = 1'b1;
    tick();
    chk("rstrel_valid", bus.rd_valid, 0);

    // First edge after reset release accepts a sample.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wr(5, 42);
    rd(5, 0);
    rd_lit("post_rst_wr", 42, 1, 42);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
